psum_acc: RTL and testbench



---
 rtl/acc_pkg.sv | 14 +
 rtl/psum_lane_add.sv | 35 +++
 rtl/psum_acc.sv | 101 ++++++++++
 tb/tb_psum_acc.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared constants and state encoding for the partial-sum accumulator and the PE stage.
package acc_pkg;

  localparam int NUM_LANE = 9;
  localparam int PSUM_W   = 32;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_ACC  = 2'd1,
    ACC_HOLD = 2'd2
  } acc_state_e;

endpackage

// File: rtl/psum_lane_add.sv
// One accumulator lane: signed add with an optional clamp (PSUM_ACC_SAT_EN) and overflow flag.
module psum_lane_add
  import acc_pkg::*;
(
  input  logic signed [PSUM_W-1:0] a,
  input  logic signed [PSUM_W-1:0] b,
  output logic signed [PSUM_W-1:0] sum,
  output logic                     ovf
);

`ifdef PSUM_ACC_SAT_EN
  function automatic logic signed [PSUM_W-1:0] sat_clamp(input logic signed [PSUM_W:0] x);
    logic signed [PSUM_W-1:0] r;
    if (x[PSUM_W] == x[PSUM_W-1]) begin
      r = x[PSUM_W-1:0];
    end else if (x[PSUM_W] == 1'b0) begin
      r = {1'b0, {(PSUM_W-1){1'b1}}};
    end else begin
      r = {1'b1, {(PSUM_W-1){1'b0}}};
    end
    return r;
  endfunction

  logic signed [PSUM_W:0] wide_p0;

  // Sign-extended sum: the two top bits disagree exactly when PSUM_W bits overflow.
  assign wide_p0 = {a[PSUM_W-1], a} + {b[PSUM_W-1], b};
  assign sum     = sat_clamp(wide_p0);
  assign ovf     = wide_p0[PSUM_W] ^ wide_p0[PSUM_W-1];
`else
  assign sum = a + b;
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/psum_acc.sv
// Partial-sum accumulator: sums NUM_LANE lanes over a programmed pass count and holds the
// result on a valid/ready handshake. Define PSUM_ACC_SAT_EN for saturating lanes.
module psum_acc
  import acc_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic [CNT_W-1:0]             pass_num_i,
  input  logic [NUM_LANE*PSUM_W-1:0]   psum_i,
  input  logic                         psum_vld_i,
  output logic                         in_rdy_o,
  output logic [NUM_LANE*PSUM_W-1:0]   acc_o,
  output logic                         acc_vld_o,
  input  logic                         acc_rdy_i,
  output logic                         busy_o,
  output logic                         ovf_o
);

  acc_state_e               state;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         num_lat;
  logic [CNT_W-1:0]         cnt_nxt;
  logic signed [PSUM_W-1:0] acc_q    [NUM_LANE];
  logic signed [PSUM_W-1:0] sum_p0   [NUM_LANE];
  logic [NUM_LANE-1:0]      lane_ovf;
  logic                     ovf_q;
  logic                     beat;
  logic                     first_beat;

  assign in_rdy_o   = (state != ACC_HOLD) || acc_rdy_i;
  assign beat       = psum_vld_i && in_rdy_o;
  // Any beat taken outside ACC opens a new group, including the zero-bubble case in HOLD.
  assign first_beat = (state != ACC_ACC);
  assign cnt_nxt    = cnt + 1'b1;
  assign ovf_o      = ovf_q;

  for (genvar g = 0; g < NUM_LANE; g++) begin : g_lane
    logic signed [PSUM_W-1:0] lane_a;
    logic signed [PSUM_W-1:0] lane_b;

    assign lane_a = first_beat ? '0 : acc_q[g];
    assign lane_b = psum_i[g*PSUM_W +: PSUM_W];

    psum_lane_add u_add (
      .a   (lane_a),
      .b   (lane_b),
      .sum (sum_p0[g]),
      .ovf (lane_ovf[g])
    );

    assign acc_o[g*PSUM_W +: PSUM_W] = acc_q[g];
  end

  // p0 -> p1: lane sums and control state register on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACC_IDLE;
      cnt       <= '0;
      num_lat   <= '0;
      ovf_q     <= 1'b0;
      acc_vld_o <= 1'b0;
      busy_o    <= 1'b0;
      for (int k = 0; k < NUM_LANE; k++) acc_q[k] <= '0;
    end else if (flush_i) begin
      state     <= ACC_IDLE;
      cnt       <= '0;
      ovf_q     <= 1'b0;
      acc_vld_o <= 1'b0;
      busy_o    <= 1'b0;
      for (int k = 0; k < NUM_LANE; k++) acc_q[k] <= '0;
    end else if (beat) begin
      for (int k = 0; k < NUM_LANE; k++) acc_q[k] <= sum_p0[k];
      busy_o <= 1'b1;
      if (first_beat) begin
        num_lat <= pass_num_i;
        cnt     <= 1;
        ovf_q   <= |lane_ovf;
        if (pass_num_i <= 1) begin
          state     <= ACC_HOLD;
          acc_vld_o <= 1'b1;
        end else begin
          state     <= ACC_ACC;
          acc_vld_o <= 1'b0;
        end
      end else begin
        cnt   <= cnt_nxt;
        ovf_q <= ovf_q | (|lane_ovf);
        if (cnt_nxt == num_lat) begin
          state     <= ACC_HOLD;
          acc_vld_o <= 1'b1;
        end
      end
    end else if (state == ACC_HOLD && acc_rdy_i) begin
      state     <= ACC_IDLE;
      acc_vld_o <= 1'b0;
      busy_o    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psum_acc.sv
// Self-checking bench for psum_acc: directed scenarios plus a randomized group stream
// checked against a per-group summing reference.
module tb_psum_acc;
  import acc_pkg::*;

  localparam int VW = NUM_LANE * PSUM_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [CNT_W-1:0]  pass_num;
  logic [VW-1:0]     psum;
  logic              psum_vld;
  logic              in_rdy;
  logic [VW-1:0]     acc;
  logic              acc_vld;
  logic              acc_rdy;
  logic              busy;
  logic              ovf;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  psum_acc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .pass_num_i (pass_num),
    .psum_i     (psum),
    .psum_vld_i (psum_vld),
    .in_rdy_o   (in_rdy),
    .acc_o      (acc),
    .acc_vld_o  (acc_vld),
    .acc_rdy_i  (acc_rdy),
    .busy_o     (busy),
    .ovf_o      (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] splat(input int v);
    logic [VW-1:0] r;
    for (int k = 0; k < NUM_LANE; k++) r[k*PSUM_W +: PSUM_W] = v;
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int k = 0; k < NUM_LANE; k++) r[k*PSUM_W +: PSUM_W] = int'($urandom_range(0, 2000)) - 1000;
    return r;
  endfunction

  function automatic logic [VW-1:0] vec_add(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    for (int k = 0; k < NUM_LANE; k++) r[k*PSUM_W +: PSUM_W] = a[k*PSUM_W +: PSUM_W] + b[k*PSUM_W +: PSUM_W];
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    vectors++;
    if (acc !== '0 || acc_vld !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0 || in_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset: acc_vld=%b busy=%b ovf=%b in_rdy=%b acc_zero=%b, want 0 0 0 1 1",
               acc_vld, busy, ovf, in_rdy, acc == '0);
    end
  endtask

  task automatic test_three_pass();
    int vals[3] = '{5, -2, 10};
    int total = 0;
    logic early = 1'b0;
    acc_rdy = 1'b1; pass_num = 8'd3;
    for (int i = 0; i < 3; i++) begin
      total += vals[i];
      psum = splat(vals[i]); psum_vld = 1'b1;
      tick();
      if (i < 2 && acc_vld !== 1'b0) early = 1'b1;
    end
    psum_vld = 1'b0;
    vectors++;
    if (early !== 1'b0) begin miscompares++; $display("FAIL three_pass_early: acc_vld rose before third beat"); end
    vectors++;
    if (acc_vld !== 1'b1 || acc !== splat(total)) begin
      miscompares++;
      $display("FAIL three_pass_sum: vld=%b lane0=%0d, want vld=1 lane0=%0d", acc_vld, $signed(acc[PSUM_W-1:0]), total);
    end
    tick();
    vectors++;
    if (acc_vld !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL three_pass_idle: vld=%b busy=%b, want 0 0", acc_vld, busy);
    end
  endtask

  task automatic test_back_pressure();
    logic [VW-1:0] exp_v, nxt_a, nxt_b;
    logic bad = 1'b0;
    for (int k = 0; k < NUM_LANE; k++) exp_v[k*PSUM_W +: PSUM_W] = k;
    acc_rdy = 1'b0; pass_num = 8'd1; psum = exp_v; psum_vld = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      psum = rand_vec(); psum_vld = 1'b1;   // dropped beats while held
      #1;
      if (in_rdy !== 1'b0 || acc_vld !== 1'b1 || acc !== exp_v) bad = 1'b1;
      tick();
    end
    vectors++;
    if (bad !== 1'b0 || acc !== exp_v) begin
      miscompares++;
      $display("FAIL back_pressure_hold: in_rdy=%b vld=%b lane8=%0d, want 0 1 8", in_rdy, acc_vld, acc[8*PSUM_W +: PSUM_W]);
    end
    nxt_a = rand_vec(); nxt_b = rand_vec();
    acc_rdy = 1'b1; pass_num = 8'd2; psum = nxt_a; psum_vld = 1'b1;
    #1;
    vectors++;
    if (in_rdy !== 1'b1) begin miscompares++; $display("FAIL back_pressure_rdy: in_rdy=%b want 1", in_rdy); end
    tick();
    vectors++;
    if (acc_vld !== 1'b0 || busy !== 1'b1 || acc !== nxt_a) begin
      miscompares++;
      $display("FAIL back_to_back_load: vld=%b busy=%b lane0=%0d want 0 1 %0d", acc_vld, busy,
               $signed(acc[PSUM_W-1:0]), $signed(nxt_a[PSUM_W-1:0]));
    end
    psum = nxt_b;
    tick();
    psum_vld = 1'b0;
    vectors++;
    if (acc_vld !== 1'b1 || acc !== vec_add(nxt_a, nxt_b)) begin
      miscompares++;
      $display("FAIL back_to_back_sum: vld=%b lane0=%0d", acc_vld, $signed(acc[PSUM_W-1:0]));
    end
    tick();
  endtask

  task automatic test_pass_boundary();
    logic [VW-1:0] exp_v, d;
    logic early = 1'b0;
    acc_rdy = 1'b1; pass_num = 8'd0; psum = splat(7); psum_vld = 1'b1;
    tick();
    psum_vld = 1'b0;
    vectors++;
    if (acc_vld !== 1'b1 || acc !== splat(7)) begin
      miscompares++;
      $display("FAIL pass_zero: vld=%b lane0=%0d want 1 7", acc_vld, $signed(acc[PSUM_W-1:0]));
    end
    tick();
    exp_v = '0;
    for (int i = 0; i < 255; i++) begin
      d = rand_vec();
      exp_v = vec_add(exp_v, d);
      pass_num = (i == 0) ? 8'd255 : 8'($urandom_range(0, 255));
      psum = d; psum_vld = 1'b1;
      tick();
      if (i < 254 && acc_vld !== 1'b0) early = 1'b1;
    end
    psum_vld = 1'b0;
    vectors++;
    if (early !== 1'b0) begin miscompares++; $display("FAIL pass_255_early: acc_vld before beat 255"); end
    vectors++;
    if (acc_vld !== 1'b1 || acc !== exp_v) begin
      miscompares++;
      $display("FAIL pass_255_sum: vld=%b lane0=%0d want 1 %0d", acc_vld, $signed(acc[PSUM_W-1:0]), $signed(exp_v[PSUM_W-1:0]));
    end
    tick();
  endtask

  task automatic test_flush();
    acc_rdy = 1'b1; pass_num = 8'd4; psum = splat(3); psum_vld = 1'b1;
    tick();
    psum = splat(9); flush = 1'b1;
    tick();
    flush = 1'b0; psum_vld = 1'b0;
    vectors++;
    if (acc !== '0 || busy !== 1'b0 || acc_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_clear: lane0=%0d busy=%b vld=%b want 0 0 0", $signed(acc[PSUM_W-1:0]), busy, acc_vld);
    end
    pass_num = 8'd2; psum = splat(4); psum_vld = 1'b1;
    tick();
    psum = splat(6);
    tick();
    psum_vld = 1'b0;
    vectors++;
    if (acc_vld !== 1'b1 || acc !== splat(10)) begin
      miscompares++;
      $display("FAIL flush_restart: vld=%b lane0=%0d want 1 10", acc_vld, $signed(acc[PSUM_W-1:0]));
    end
    tick();
  endtask

  task automatic test_overflow();
    logic [VW-1:0] d;
    logic [PSUM_W-1:0] want_lane0;
    logic want_ovf;
`ifdef PSUM_ACC_SAT_EN
    want_lane0 = 32'h7FFF_FFFF; want_ovf = 1'b1;
`else
    want_lane0 = 32'h8000_0010; want_ovf = 1'b0;
`endif
    acc_rdy = 1'b1; pass_num = 8'd2;
    d = '0; d[PSUM_W-1:0] = 32'h7FFF_FFF0;
    psum = d; psum_vld = 1'b1;
    tick();
    d[PSUM_W-1:0] = 32'h0000_0020; psum = d;
    tick();
    psum_vld = 1'b0;
    vectors++;
    if (acc[PSUM_W-1:0] !== want_lane0 || ovf !== want_ovf || acc[VW-1:PSUM_W] !== '0) begin
      miscompares++;
      $display("FAIL overflow: lane0=%h ovf=%b want %h %b", acc[PSUM_W-1:0], ovf, want_lane0, want_ovf);
    end
    tick();
    pass_num = 8'd1; psum = splat(1); psum_vld = 1'b1;
    tick();
    psum_vld = 1'b0;
    vectors++;
    if (ovf !== 1'b0 || acc !== splat(1)) begin
      miscompares++;
      $display("FAIL overflow_clear: ovf=%b lane0=%0d want 0 1", ovf, $signed(acc[PSUM_W-1:0]));
    end
    tick();
  endtask

  task automatic test_random();
    logic [VW-1:0] q[$];
    logic [VW-1:0] cur, data;
    int groups_left = 30;
    int left = 0;
    int budget = 0;
    int n;
    bit pend, exp_rdy, accept;
    cur = '0; data = '0;
    while ((groups_left > 0 || left > 0 || q.size() > 0) && budget < 3000) begin
      budget++;
      acc_rdy  = ($urandom_range(0, 3) != 0);
      pend     = (q.size() > 0);
      exp_rdy  = !pend || acc_rdy;
      psum_vld = 1'b0;
      accept   = 1'b0;
      if (exp_rdy && (left > 0 || groups_left > 0) && $urandom_range(0, 3) != 0) begin
        if (left == 0) begin
          n = $urandom_range(0, 6);
          pass_num = 8'(n);
          left = (n < 2) ? 1 : n;
          groups_left--;
          cur = '0;
        end else begin
          pass_num = 8'($urandom_range(0, 255));
        end
        data = rand_vec();
        psum = data; psum_vld = 1'b1; accept = 1'b1;
      end
      #1;
      vectors++;
      if (in_rdy !== exp_rdy) begin miscompares++; $display("FAIL rand_in_rdy: %b want %b", in_rdy, exp_rdy); end
      vectors++;
      if (acc_vld !== pend) begin miscompares++; $display("FAIL rand_acc_vld: %b want %b", acc_vld, pend); end
      if (pend) begin
        vectors++;
        if (acc !== q[0]) begin
          miscompares++;
          $display("FAIL rand_result: lane0=%0d want %0d", $signed(acc[PSUM_W-1:0]), $signed(q[0][PSUM_W-1:0]));
        end
      end
      tick();
      if (pend && acc_rdy) void'(q.pop_front());
      if (accept) begin
        cur = vec_add(cur, data);
        left--;
        if (left == 0) q.push_back(cur);
      end
    end
    psum_vld = 1'b0;
    vectors++;
    if (budget >= 3000) begin miscompares++; $display("FAIL rand_timeout: %0d groups pending", q.size() + groups_left); end
    acc_rdy = 1'b1;
    tick();
  endtask

  task automatic test_sync_reset();
    acc_rdy = 1'b0; pass_num = 8'd1; psum = splat(42); psum_vld = 1'b1;
    tick();
    psum_vld = 1'b0;
    vectors++;
    if (acc_vld !== 1'b1) begin miscompares++; $display("FAIL sreset_hold: vld=%b want 1", acc_vld); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++;
    if (acc !== '0 || acc_vld !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0 || in_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL sreset: vld=%b busy=%b ovf=%b in_rdy=%b acc_zero=%b want 0 0 0 1 1",
               acc_vld, busy, ovf, in_rdy, acc == '0);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; pass_num = '0; psum = '0; psum_vld = 1'b0; acc_rdy = 1'b0;
    test_reset();
    test_three_pass();
    test_back_pressure();
    test_pass_boundary();
    test_flush();
    test_overflow();
    test_random();
    test_sync_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
